// File: rtl/multi_range_finder_pkg.sv
// range_finder_pkg
// Shared types and helpers for multi_range_finder and range_channel.
//   - rf_state_t       : session FSM state encoding
//   - rf_min_sentinel  : value that any real sample will undercut (type max)
//   - rf_max_sentinel  : value that any real sample will exceed (type min)
//   - rf_less          : width-aware signed/unsigned less-than
// Helpers work on RF_MAX_W-bit containers; callers zero-extend their
// WIDTH-bit operands and truncate results back to WIDTH bits.
// WIDTH is therefore limited to at most RF_MAX_W bits.
package range_finder_pkg;

  localparam int RF_MAX_W = 64;

  typedef enum logic [1:0] {
    RF_IDLE  = 2'd0,
    RF_RUN   = 2'd1,
    RF_ERROR = 2'd2
  } rf_state_t;

  // Single set bit at the sign position of a width-bit value.
  function automatic logic [RF_MAX_W-1:0] rf_msb(input int width);
    return RF_MAX_W'(1) << (width - 1);
  endfunction

  function automatic logic [RF_MAX_W-1:0] rf_min_sentinel(input int width,
                                                         input logic signed_mode);
    logic [RF_MAX_W-1:0] mask;
    mask = (width >= RF_MAX_W) ? '1 : ((RF_MAX_W'(1) << width) - RF_MAX_W'(1));
    return signed_mode ? (mask & ~rf_msb(width)) : mask;
  endfunction

  function automatic logic [RF_MAX_W-1:0] rf_max_sentinel(input int width,
                                                         input logic signed_mode);
    return signed_mode ? rf_msb(width) : '0;
  endfunction

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so one unsigned comparator serves both modes.
  function automatic logic rf_less(input logic [RF_MAX_W-1:0] a,
                                   input logic [RF_MAX_W-1:0] b,
                                   input int width,
                                   input logic signed_mode);
    logic [RF_MAX_W-1:0] bias;
    bias = signed_mode ? rf_msb(width) : '0;
    return (a ^ bias) < (b ^ bias);
  endfunction

endpackage

// File: rtl/multi_range_finder_channel.sv
// range_channel
// One running min/max tracker. Initialises on init_i (to the sample when
// valid_i, else to the empty sentinel) and otherwise folds in each valid
// sample. Next-state values are exported so the owner can latch a result
// that includes the sample presented in the same cycle.
// Ports:
//   clock, reset_n  : clock / asynchronous active-low reset
//   init_i          : start a fresh tracking window this cycle
//   valid_i         : sample_i is to be used this cycle
//   sample_i        : channel sample
//   min_next_o      : running minimum after this cycle
//   max_next_o      : running maximum after this cycle
module range_channel
  import range_finder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             init_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [WIDTH-1:0] min_next_o,
  output logic [WIDTH-1:0] max_next_o
);

  localparam logic IS_SIGNED = (SIGNED != 0);
  localparam logic [WIDTH-1:0] MIN_SENT = WIDTH'(rf_min_sentinel(WIDTH, IS_SIGNED));
  localparam logic [WIDTH-1:0] MAX_SENT = WIDTH'(rf_max_sentinel(WIDTH, IS_SIGNED));

  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (init_i) begin
      min_d = valid_i ? sample_i : MIN_SENT;
      max_d = valid_i ? sample_i : MAX_SENT;
    end else if (valid_i) begin
      if (rf_less(RF_MAX_W'(sample_i), RF_MAX_W'(min_q), WIDTH, IS_SIGNED)) begin
        min_d = sample_i;
      end
      if (rf_less(RF_MAX_W'(max_q), RF_MAX_W'(sample_i), WIDTH, IS_SIGNED)) begin
        max_d = sample_i;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      min_q <= MIN_SENT;
      max_q <= MAX_SENT;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_next_o = min_d;
  assign max_next_o = max_d;

endmodule

// File: rtl/multi_range_finder.sv
// multi_range_finder
// Tracks running min/max/range on NUM_CH channels sharing one go/finish
// session and one sample strobe. Results latch on the edge that ends a
// finish cycle in RUN and are flagged by a one-cycle result_valid.
// Ports:
//   clock, reset_n          : clock / asynchronous active-low reset
//   data_in [NUM_CH*WIDTH]  : packed samples, channel k at [k*WIDTH +: WIDTH]
//   data_valid              : data_in qualifier
//   go, finish              : session start/restart and end
//   min_out/max_out/range_out : latched per-channel results
//   result_valid            : one-cycle pulse on each new latch
//   empty                   : last latched session had no valid samples
//   sample_count [COUNT_W]  : latched saturated sample count
//                             (only with MULTI_RANGE_FINDER_COUNT_EN)
//   debug_error             : high while in ERROR
// Optional feature macro: MULTI_RANGE_FINDER_COUNT_EN
module multi_range_finder
  import range_finder_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_CH  = 4,
  parameter int SIGNED  = 0,
  parameter int COUNT_W = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  input  logic                    data_valid,
  input  logic                    go,
  input  logic                    finish,
  output logic [NUM_CH*WIDTH-1:0] min_out,
  output logic [NUM_CH*WIDTH-1:0] max_out,
  output logic [NUM_CH*WIDTH-1:0] range_out,
  output logic                    result_valid,
  output logic                    empty,
`ifdef MULTI_RANGE_FINDER_COUNT_EN
  output logic [COUNT_W-1:0]      sample_count,
`endif
  output logic                    debug_error
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  rf_state_t state_q;

  logic init_c;   // trackers restart this cycle
  logic upd_c;    // valid sample folds into the running session
  logic latch_c;  // session ends cleanly; results latch on this edge

  logic [COUNT_W-1:0] count_q, count_d;

  logic [NUM_CH*WIDTH-1:0] min_next, max_next, range_next;
  logic [NUM_CH*WIDTH-1:0] min_out_q, max_out_q, range_out_q;
  logic                    result_valid_q, empty_q;
`ifdef MULTI_RANGE_FINDER_COUNT_EN
  logic [COUNT_W-1:0]      sample_count_q;
`endif

  always_comb begin
    init_c  = 1'b0;
    upd_c   = 1'b0;
    latch_c = 1'b0;
    unique case (state_q)
      RF_IDLE:  init_c = go && !finish;
      RF_RUN: begin
        init_c  = go && !finish;
        latch_c = finish && !go;
        // Includes the finish-cycle sample; go&finish discards everything.
        upd_c   = data_valid && !go;
      end
      RF_ERROR: init_c = go;
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (init_c) begin
      count_d = data_valid ? COUNT_W'(1) : '0;
    end else if (upd_c && (count_q != COUNT_MAX)) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    range_channel #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
    ) u_ch (
      .clock      (clock),
      .reset_n    (reset_n),
      .init_i     (init_c),
      .valid_i    (data_valid && (init_c || upd_c)),
      .sample_i   (data_in[gi*WIDTH +: WIDTH]),
      .min_next_o (min_next[gi*WIDTH +: WIDTH]),
      .max_next_o (max_next[gi*WIDTH +: WIDTH])
    );
    // Modular subtraction gives the correct unsigned span in both modes.
    assign range_next[gi*WIDTH +: WIDTH] =
        max_next[gi*WIDTH +: WIDTH] - min_next[gi*WIDTH +: WIDTH];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RF_IDLE;
      min_out_q      <= '0;
      max_out_q      <= '0;
      range_out_q    <= '0;
      result_valid_q <= 1'b0;
      empty_q        <= 1'b0;
`ifdef MULTI_RANGE_FINDER_COUNT_EN
      sample_count_q <= '0;
`endif
    end else begin
      result_valid_q <= latch_c;
      unique case (state_q)
        RF_IDLE: begin
          if (finish)  state_q <= RF_ERROR;
          else if (go) state_q <= RF_RUN;
        end
        RF_RUN: begin
          if (go && finish) state_q <= RF_ERROR;
          else if (finish)  state_q <= RF_IDLE;
        end
        RF_ERROR: begin
          if (go) state_q <= RF_RUN;
        end
        default: state_q <= RF_IDLE;
      endcase
      if (latch_c) begin
        if (count_d != '0) begin
          min_out_q   <= min_next;
          max_out_q   <= max_next;
          range_out_q <= range_next;
          empty_q     <= 1'b0;
        end else begin
          min_out_q   <= '0;
          max_out_q   <= '0;
          range_out_q <= '0;
          empty_q     <= 1'b1;
        end
`ifdef MULTI_RANGE_FINDER_COUNT_EN
        sample_count_q <= count_d;
`endif
      end
    end
  end

  assign min_out      = min_out_q;
  assign max_out      = max_out_q;
  assign range_out    = range_out_q;
  assign result_valid = result_valid_q;
  assign empty        = empty_q;
`ifdef MULTI_RANGE_FINDER_COUNT_EN
  assign sample_count = sample_count_q;
`endif
  assign debug_error  = (state_q == RF_ERROR);

endmodule
